// File: rtl/e203_tohost_mbox.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | e203_tohost_mbox : ICB-slave tohost mailbox reporting test done/pass status |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+
module e203_tohost_mbox #(
  parameter int          AW       = 12,
  parameter int unsigned DONE_CNT = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_icb_cmd_valid,
  output logic          i_icb_cmd_ready,
  input  logic [AW-1:0] i_icb_cmd_addr,
  input  logic          i_icb_cmd_read,
  input  logic [31:0]   i_icb_cmd_wdata,
  input  logic [3:0]    i_icb_cmd_wmask,
  output logic          i_icb_rsp_valid,
  input  logic          i_icb_rsp_ready,
  output logic [31:0]   i_icb_rsp_rdata,
  output logic          i_icb_rsp_err,
  input  logic          cmt_valid,
  output logic          test_done,
  output logic          test_pass
);

  localparam logic [2:0]  c_OFF_TOHOST    = 3'd0;
  localparam logic [2:0]  c_OFF_STATUS    = 3'd1;
  localparam logic [2:0]  c_OFF_CYCLE     = 3'd2;
  localparam logic [2:0]  c_OFF_INSTRET   = 3'd3;
  localparam logic [2:0]  c_OFF_END_CYCLE = 3'd4;
  localparam logic [2:0]  c_OFF_FIRST_VAL = 3'd5;
  localparam logic [2:0]  c_OFF_CNT       = 3'd6;
  localparam logic [2:0]  c_OFF_CTRL      = 3'd7;
  localparam logic [31:0] c_DONE_CNT      = 32'(DONE_CNT);
  localparam logic [31:0] c_CNT_MAX       = 32'hFFFF_FFFF;

  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;
  logic [31:0] r_tohost;
  logic [31:0] r_cycle;
  logic [31:0] r_instret;
  logic [31:0] r_end_cycle;
  logic [31:0] r_first_val;
  logic [31:0] r_tohost_cnt;
  logic        r_done;
  logic        r_first_seen;

  logic [2:0]  w_off;
  logic        w_misalign;
  logic        w_accept;
  logic        w_wr_ok;
  logic [31:0] w_wval;
  logic        w_tohost_wr;
  logic        w_clear;
  logic        w_ro_wr;
  logic        w_err;
  logic [31:0] w_cnt_nxt;
  logic        w_pass;
  logic [31:0] w_rdval;
  logic        w_unused;

  assign w_off           = i_icb_cmd_addr[4:2];
  assign w_misalign      = |i_icb_cmd_addr[1:0];
  assign i_icb_cmd_ready = ~r_rsp_valid | i_icb_rsp_ready;
  assign w_accept        = i_icb_cmd_valid & i_icb_cmd_ready;
  assign w_wr_ok         = w_accept & ~i_icb_cmd_read & ~w_misalign;
  assign w_wval          = i_icb_cmd_wdata & {{8{i_icb_cmd_wmask[3]}}, {8{i_icb_cmd_wmask[2]}},
                                              {8{i_icb_cmd_wmask[1]}}, {8{i_icb_cmd_wmask[0]}}};
  assign w_tohost_wr     = w_wr_ok & (w_off == c_OFF_TOHOST);
  assign w_clear         = w_wr_ok & (w_off == c_OFF_CTRL) & w_wval[0];
  assign w_ro_wr         = ~i_icb_cmd_read & (w_off != c_OFF_TOHOST) & (w_off != c_OFF_CTRL);
  assign w_err           = w_misalign | w_ro_wr;
  assign w_cnt_nxt       = (r_tohost_cnt == c_CNT_MAX) ? r_tohost_cnt : r_tohost_cnt + 32'd1;
  assign w_pass          = (r_first_val == 32'd1);
  assign w_unused        = ^i_icb_cmd_addr[AW-1:5];

  assign i_icb_rsp_valid = r_rsp_valid;
  assign i_icb_rsp_rdata = r_rsp_rdata;
  assign i_icb_rsp_err   = r_rsp_err;
  assign test_done       = r_done;
  assign test_pass       = r_done & w_pass;

  always_comb begin
    w_rdval = 32'd0;
    case (w_off)
      c_OFF_TOHOST:    w_rdval = r_tohost;
      c_OFF_STATUS:    w_rdval = {29'd0, r_first_seen, w_pass, r_done};
      c_OFF_CYCLE:     w_rdval = r_cycle;
      c_OFF_INSTRET:   w_rdval = r_instret;
      c_OFF_END_CYCLE: w_rdval = r_end_cycle;
      c_OFF_FIRST_VAL: w_rdval = r_first_val;
      c_OFF_CNT:       w_rdval = r_tohost_cnt;
      default:         w_rdval = 32'd0;
    endcase
  end

  // Response only advances on accept, so it holds while the master stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_err   <= w_err;
      r_rsp_rdata <= (i_icb_cmd_read & ~w_misalign) ? w_rdval : 32'd0;
    end else if (i_icb_rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tohost     <= 32'd0;
      r_cycle      <= 32'd0;
      r_instret    <= 32'd0;
      r_end_cycle  <= 32'd0;
      r_first_val  <= 32'd0;
      r_tohost_cnt <= 32'd0;
      r_done       <= 1'b0;
      r_first_seen <= 1'b0;
    end else if (w_clear) begin
      r_tohost     <= 32'd0;
      r_cycle      <= 32'd0;
      r_instret    <= 32'd0;
      r_end_cycle  <= 32'd0;
      r_first_val  <= 32'd0;
      r_tohost_cnt <= 32'd0;
      r_done       <= 1'b0;
      r_first_seen <= 1'b0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      // Pulse coinciding with the first write still counts: first_seen is still 0.
      if (cmt_valid && !r_first_seen) begin
        r_instret <= r_instret + 32'd1;
      end
      if (w_tohost_wr) begin
        r_tohost     <= w_wval;
        r_tohost_cnt <= w_cnt_nxt;
        if (w_cnt_nxt == c_DONE_CNT) begin
          r_done <= 1'b1;
        end
        if (!r_first_seen) begin
          r_first_seen <= 1'b1;
          r_end_cycle  <= r_cycle;
          r_first_val  <= w_wval;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_e203_tohost_mbox.sv
`default_nettype none
// tb_e203_tohost_mbox : directed scoreboard bench for the tohost mailbox.
module tb_e203_tohost_mbox;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [11:0] cmd_addr = 12'h0;
  logic        cmd_read = 1'b1;
  logic [31:0] cmd_wdata = 32'h0;
  logic [3:0]  cmd_wmask = 4'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        cmt_valid = 1'b0;
  logic        test_done;
  logic        test_pass;

  int vectors = 0;
  int miscompares = 0;
  int unsigned tb_cyc = 0;
  int unsigned cyc_base = 0;

  logic [31:0] exp_rd[$];
  logic        exp_err[$];
  logic        exp_ck[$];
  string       exp_tag[$];

  e203_tohost_mbox #(.AW(12), .DONE_CNT(8)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_icb_cmd_valid (cmd_valid),
    .i_icb_cmd_ready (cmd_ready),
    .i_icb_cmd_addr  (cmd_addr),
    .i_icb_cmd_read  (cmd_read),
    .i_icb_cmd_wdata (cmd_wdata),
    .i_icb_cmd_wmask (cmd_wmask),
    .i_icb_rsp_valid (rsp_valid),
    .i_icb_rsp_ready (rsp_ready),
    .i_icb_rsp_rdata (rsp_rdata),
    .i_icb_rsp_err   (rsp_err),
    .cmt_valid       (cmt_valid),
    .test_done       (test_done),
    .test_pass       (test_pass)
  );

  always #5 clk = ~clk;

  // Reference cycle count: edges seen while out of reset.
  always @(posedge clk) if (rst_n) tb_cyc <= tb_cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string t, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", t, got, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] er, input logic ee, input logic ck, input string t);
    exp_rd.push_back(er);
    exp_err.push_back(ee);
    exp_ck.push_back(ck);
    exp_tag.push_back(t);
  endtask

  task automatic pop_check();
    logic [31:0] er;
    logic        ee;
    logic        ck;
    string       t;
    vectors++;
    assert (exp_rd.size() != 0) else begin
      miscompares++;
      $error("FAIL rsp_order: observed=extra_response expected=none");
    end
    if (exp_rd.size() != 0) begin
      er = exp_rd.pop_front();
      ee = exp_err.pop_front();
      ck = exp_ck.pop_front();
      t  = exp_tag.pop_front();
      chk({t, "_err"}, 32'(rsp_err), 32'(ee));
      if (ck) chk({t, "_rdata"}, rsp_rdata, er);
    end
  endtask

  task automatic xact(input logic rd, input logic [11:0] a, input logic [31:0] wd,
                      input logic [3:0] wm, input logic c, input logic clr,
                      input logic [31:0] er, input logic ee, input string t);
    push_exp(er, ee, rd || (a[1:0] != 2'b00), t);
    cmd_valid = 1'b1; cmd_read = rd; cmd_addr = a; cmd_wdata = wd; cmd_wmask = wm;
    cmt_valid = c;
    @(negedge clk);
    chk({t, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    if (clr) cyc_base = tb_cyc;
    cmd_valid = 1'b0; cmt_valid = 1'b0; cmd_read = 1'b1;
    @(negedge clk);
    chk({t, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    pop_check();
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] er, input logic ee, input string t);
    xact(1'b1, a, 32'h0, 4'h0, 1'b0, 1'b0, er, ee, t);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] m,
                    input logic ee, input string t);
    xact(1'b0, a, d, m, 1'b0, 1'b0, 32'h0, ee, t);
  endtask

  task automatic pulse_cmt(input int n);
    for (int i = 0; i < n; i++) begin
      cmt_valid = 1'b1;
      @(posedge clk); #1;
      cmt_valid = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int guard;
    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    chk("rst_done", 32'(test_done), 32'd0);
    chk("rst_pass", 32'(test_pass), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("idle_cycles", tb_cyc - cyc_base, 32'd10);
    rd(12'h008, tb_cyc - cyc_base, 1'b0, "cycle_after_idle");
    rd(12'h004, 32'd0, 1'b0, "status_reset");

    // First write at cycle 40 after five committed instructions
    pulse_cmt(5);
    guard = 0;
    while ((tb_cyc - cyc_base) < 40 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("reach_cycle40", tb_cyc - cyc_base, 32'd40);
    wr(12'h000, 32'd1, 4'hF, 1'b0, "tohost_first");
    rd(12'h010, 32'd40, 1'b0, "end_cycle");
    rd(12'h00C, 32'd5, 1'b0, "instret");
    rd(12'h014, 32'd1, 1'b0, "first_val");
    rd(12'h004, 32'd6, 1'b0, "status_seen_pass");
    rd(12'h018, 32'd1, 1'b0, "cnt_one");
    chk("pass_not_done", 32'(test_pass), 32'd0);
    pulse_cmt(3);
    rd(12'h00C, 32'd5, 1'b0, "instret_frozen");

    // Error responses and aliasing
    wr(12'h008, 32'h0, 4'hF, 1'b1, "wr_cycle_ro");
    wr(12'h010, 32'h1234, 4'hF, 1'b1, "wr_endcyc_ro");
    rd(12'h010, 32'd40, 1'b0, "end_cycle_kept");
    rd(12'h002, 32'd0, 1'b1, "rd_misaligned");
    wr(12'h001, 32'd5, 4'hF, 1'b1, "wr_misaligned");
    rd(12'h000, 32'd1, 1'b0, "tohost_kept");
    rd(12'h018, 32'd1, 1'b0, "cnt_kept");
    rd(12'h01C, 32'd0, 1'b0, "rd_ctrl");
    rd(12'h038, 32'd1, 1'b0, "alias_cnt");

    // Clear, with a coincident commit pulse that must be discarded
    xact(1'b0, 12'h01C, 32'd1, 4'hF, 1'b1, 1'b1, 32'h0, 1'b0, "ctrl_clear");
    chk("clr_done", 32'(test_done), 32'd0);
    rd(12'h004, 32'd0, 1'b0, "clr_status");
    rd(12'h00C, 32'd0, 1'b0, "clr_instret");
    rd(12'h018, 32'd0, 1'b0, "clr_cnt");
    rd(12'h014, 32'd0, 1'b0, "clr_first_val");
    rd(12'h010, 32'd0, 1'b0, "clr_end_cycle");
    rd(12'h000, 32'd0, 1'b0, "clr_tohost");
    rd(12'h008, tb_cyc - cyc_base, 1'b0, "clr_cycle");

    // Eight back-to-back writes of 1
    for (int i = 0; i < 8; i++) push_exp(32'h0, 1'b0, 1'b0, "b2b");
    cmd_valid = 1'b1; cmd_read = 1'b0; cmd_addr = 12'h000; cmd_wdata = 32'd1; cmd_wmask = 4'hF;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("b2b_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("b2b_done_early", 32'(test_done), 32'd0);
      if (i > 0) begin
        chk("b2b_rsp_valid", 32'(rsp_valid), 32'd1);
        pop_check();
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0; cmd_read = 1'b1;
    @(negedge clk);
    chk("b2b_rsp_valid_last", 32'(rsp_valid), 32'd1);
    pop_check();
    chk("b2b_done", 32'(test_done), 32'd1);
    chk("b2b_pass", 32'(test_pass), 32'd1);
    @(posedge clk); #1;
    rd(12'h018, 32'd8, 1'b0, "b2b_cnt");
    rd(12'h004, 32'd7, 1'b0, "b2b_status");

    // Failing first value, masked to one byte, coincident commit pulse counted
    xact(1'b0, 12'h01C, 32'd1, 4'hF, 1'b0, 1'b1, 32'h0, 1'b0, "ctrl_clear2");
    pulse_cmt(2);
    xact(1'b0, 12'h000, 32'hFFFF_FF07, 4'h1, 1'b1, 1'b0, 32'h0, 1'b0, "first_masked");
    for (int i = 0; i < 7; i++) wr(12'h000, 32'd1, 4'hF, 1'b0, "more_ones");
    chk("fail_done", 32'(test_done), 32'd1);
    chk("fail_pass", 32'(test_pass), 32'd0);
    rd(12'h014, 32'd7, 1'b0, "fail_first_val");
    rd(12'h00C, 32'd3, 1'b0, "fail_instret");
    rd(12'h004, 32'd5, 1'b0, "fail_status");
    wr(12'h000, 32'hDEAD, 4'h0, 1'b0, "wmask_zero");
    rd(12'h000, 32'd0, 1'b0, "wmask_zero_val");
    rd(12'h018, 32'd9, 1'b0, "wmask_zero_cnt");
    wr(12'h000, 32'hA5A5_5A5A, 4'hF, 1'b0, "tohost_pattern");

    // Response back-pressure for three cycles
    rsp_ready = 1'b0;
    push_exp(32'hA5A5_5A5A, 1'b0, 1'b1, "stall_a");
    cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 12'h000;
    @(negedge clk);
    chk("stall_a_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    push_exp(32'd10, 1'b0, 1'b1, "stall_b");
    cmd_addr = 12'h018;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("stall_rdata", rsp_rdata, 32'hA5A5_5A5A);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("unstall_ready", 32'(cmd_ready), 32'd1);
    pop_check();
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("stall_b_valid", 32'(rsp_valid), 32'd1);
    pop_check();
    @(posedge clk); #1;

    // Reset with a response pending
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 12'h004;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("pend_rsp_valid", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_done", 32'(test_done), 32'd0);
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    cyc_base = tb_cyc;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    @(posedge clk); #1;
    rd(12'h004, 32'd0, 1'b0, "post_rst_status");
    rd(12'h008, tb_cyc - cyc_base, 1'b0, "post_rst_cycle");
    chk("queue_empty", 32'(exp_rd.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
